jacobi_residual: RTL and testbench

//   Forward-direction companion to the Jacobi solver. Takes A, b and a candidate solution x,
//   and computes the residual r = b - A*x in the solver's signed fixed-point format.

---
 rtl/jacobi_residual.sv | 178 +++++++++++++++++
 tb/tb_jacobi_residual.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/jacobi_residual.sv
// Residual r = b - A*x for the Jacobi solver's signed Q-format words.
// One multiply-accumulate per clock. Reports per-row residuals, max |r|, a convergence flag
// against TOLERANCE, and a sticky saturation flag. A, x and b are read live, not captured.
module jacobi_residual #(
    parameter int unsigned SIZE      = 3,
    parameter int unsigned PRECISION = 16,
    parameter int unsigned POINT     = 8,
    parameter int unsigned TOLERANCE = 4
) (
    input  logic                                           clk,
    input  logic                                           I_RSTn,
    input  logic [SIZE-1:0][SIZE-1:0][PRECISION+POINT-1:0] A,
    input  logic [SIZE-1:0][PRECISION+POINT-1:0]           x,
    input  logic [SIZE-1:0][PRECISION+POINT-1:0]           b,
    input  logic                                           start,
    output logic [SIZE-1:0][PRECISION+POINT-1:0]           r,
    output logic [PRECISION+POINT-1:0]                     max_abs_r,
    output logic                                           converged,
    output logic                                           sat,
    output logic                                           ready
);

    localparam int unsigned W  = PRECISION + POINT;
    // Wide enough that SIZE full products can never wrap the accumulator.
    localparam int unsigned AW = 2 * W + $clog2(SIZE) + 1;
    localparam int unsigned IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [IW-1:0] LastIdx = IW'(SIZE - 1);
    localparam logic signed [AW-1:0] MaxV = {{(AW - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [AW-1:0] MinV = {{(AW - W + 1){1'b1}}, {(W - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StRow, StDone} state_e;

    state_e                     state_q, state_d;
    logic [IW-1:0]              i_q, i_d;
    logic [IW-1:0]              j_q, j_d;
    logic signed [AW-1:0]       acc_q, acc_d;
    logic [SIZE-1:0][W-1:0]     r_q, r_d;
    logic [W-1:0]               max_q, max_d;
    logic                       conv_q, conv_d;
    logic                       sat_q, sat_d;
    logic                       ready_q, ready_d;

    logic signed [W-1:0]        a_sel;
    logic signed [W-1:0]        x_sel;
    logic signed [2*W-1:0]      prod;
    logic signed [2*W-1:0]      prod_sh;
    logic signed [AW-1:0]       prod_ext;
    logic signed [AW-1:0]       b_ext;
    logic signed [AW-1:0]       diff;
    logic                       ovf_hi;
    logic                       ovf_lo;
    logic [W-1:0]               r_new;
    logic [W-1:0]               r_abs;
    logic [W-1:0]               max_new;

    // Arithmetic: floor-shifted product, row difference, clamp and magnitude.
    always_comb begin
        a_sel    = A[i_q][j_q];
        x_sel    = x[j_q];
        prod     = a_sel * x_sel;
        prod_sh  = prod >>> POINT;
        prod_ext = {{(AW - 2 * W){prod_sh[2*W-1]}}, prod_sh};
        b_ext    = {{(AW - W){b[i_q][W-1]}}, b[i_q]};
        diff     = b_ext - acc_q;
        ovf_hi   = diff > MaxV;
        ovf_lo   = diff < MinV;
        if (ovf_hi) begin
            r_new = MaxV[W-1:0];
        end else if (ovf_lo) begin
            r_new = MinV[W-1:0];
        end else begin
            r_new = diff[W-1:0];
        end
        // Unsigned magnitude: -2^(W-1) maps to 2^(W-1) without overflow.
        r_abs   = r_new[W-1] ? (~r_new + W'(1)) : r_new;
        max_new = (r_abs > max_q) ? r_abs : max_q;
    end

    // State register.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start wins in every state.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = StMac;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StIdle;
                StMac:   state_d = (j_q == LastIdx) ? StRow : StMac;
                StRow:   state_d = (i_q == LastIdx) ? StDone : StMac;
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath and output next-state values, decoded from the current state.
    always_comb begin
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        r_d     = r_q;
        max_d   = max_q;
        conv_d  = conv_q;
        sat_d   = sat_q;
        ready_d = ready_q;
        if (start) begin
            // r is deliberately left alone until each row is rewritten.
            i_d     = '0;
            j_d     = '0;
            acc_d   = '0;
            max_d   = '0;
            conv_d  = 1'b0;
            sat_d   = 1'b0;
            ready_d = 1'b0;
        end else begin
            unique case (state_q)
                StMac: begin
                    acc_d = acc_q + prod_ext;
                    j_d   = (j_q == LastIdx) ? '0 : j_q + IW'(1);
                end
                StRow: begin
                    r_d[i_q] = r_new;
                    sat_d    = sat_q | ovf_hi | ovf_lo;
                    max_d    = max_new;
                    acc_d    = '0;
                    if (i_q == LastIdx) begin
                        i_d     = '0;
                        ready_d = 1'b1;
                        conv_d  = max_new <= W'(TOLERANCE);
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            r_q     <= '0;
            max_q   <= '0;
            conv_q  <= 1'b0;
            sat_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            r_q     <= r_d;
            max_q   <= max_d;
            conv_q  <= conv_d;
            sat_q   <= sat_d;
            ready_q <= ready_d;
        end
    end

    assign r         = r_q;
    assign max_abs_r = max_q;
    assign converged = conv_q;
    assign sat       = sat_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_jacobi_residual.sv
// Directed bench for jacobi_residual with hand-computed residuals (SIZE=3, Q16.8).
module tb_jacobi_residual;

    localparam int W = 24;
    localparam int N = 3;

    logic                        clk = 1'b0;
    logic                        I_RSTn;
    logic                        start;
    logic [N-1:0][N-1:0][W-1:0]  A;
    logic [N-1:0][W-1:0]         x;
    logic [N-1:0][W-1:0]         b;
    logic [N-1:0][W-1:0]         r;
    logic [W-1:0]                max_abs_r;
    logic                        converged;
    logic                        sat;
    logic                        ready;

    int n_pass  = 0;
    int n_total = 0;

    jacobi_residual #(
        .SIZE      (3),
        .PRECISION (16),
        .POINT     (8),
        .TOLERANCE (4)
    ) u_dut (
        .clk       (clk),
        .I_RSTn    (I_RSTn),
        .A         (A),
        .x         (x),
        .b         (b),
        .start     (start),
        .r         (r),
        .max_abs_r (max_abs_r),
        .converged (converged),
        .sat       (sat),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] q(input int v);
        q = v[W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        A = '0;
        x = '0;
        b = '0;
    endtask

    // Pulse start (edge 0) and report the edge on which ready first reads high.
    task automatic run(input string tag);
        int first;
        first = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 40 && first < 0; e++) begin
            tick();
            if (ready) first = e;
        end
        check_eq({tag, "_latency"}, first, 12);
    endtask

    task automatic check_out(input string tag, input int r0, input int r1, input int r2,
                             input int mx, input logic cv, input logic st);
        check_eq({tag, "_r0"}, r[0], q(r0));
        check_eq({tag, "_r1"}, r[1], q(r1));
        check_eq({tag, "_r2"}, r[2], q(r2));
        check_eq({tag, "_max"}, max_abs_r, q(mx));
        check_eq({tag, "_conv"}, converged, cv);
        check_eq({tag, "_sat"}, sat, st);
    endtask

    task automatic load_general();
        clear_inputs();
        A[0][0] = q(1024); A[0][1] = q(256); A[0][2] = q(0);
        A[1][0] = q(256);  A[1][1] = q(768); A[1][2] = q(256);
        A[2][0] = q(0);    A[2][1] = q(256); A[2][2] = q(512);
        x[0] = q(256); x[1] = q(256); x[2] = q(256);
        b[0] = q(1290); b[1] = q(1280); b[2] = q(760);
    endtask

    initial begin
        I_RSTn = 1'b0;
        start  = 1'b0;
        clear_inputs();
        #12;
        check_out("reset", 0, 0, 0, 0, 1'b0, 1'b0);
        check_eq("reset_ready", ready, 1'b0);
        I_RSTn = 1'b1;
        tick();

        // Identity matrix, b = x.
        clear_inputs();
        A[0][0] = q(256); A[1][1] = q(256); A[2][2] = q(256);
        x[0] = q(256); x[1] = q(512); x[2] = q(-256);
        b = x;
        run("ident");
        check_out("ident", 0, 0, 0, 0, 1'b1, 1'b0);

        // General matrix: rows sum to 1280, 1280, 768.
        load_general();
        run("gen");
        check_out("gen", 10, 0, -8, 10, 1'b0, 1'b0);

        // Floor shift: 1>>>8 = 0, -1>>>8 = -1.
        clear_inputs();
        A[0][0] = q(1);
        A[1][0] = q(-1);
        x[0]    = q(1);
        run("floor");
        check_out("floor", 0, 1, 0, 1, 1'b1, 1'b0);

        // Negative saturation of row 0.
        clear_inputs();
        A[0][0] = q(32'h7FFFFF);
        x[0]    = q(32'h7FFFFF);
        b[0]    = q(-32'sh800000);
        run("sat");
        check_out("sat", -32'sh800000, 0, 0, 32'h800000, 1'b0, 1'b1);

        // Restart at edge 5 with a new b; latency counts from the second start.
        load_general();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        check_eq("restart_midrun_ready", ready, 1'b0);
        b[0] = q(1280); b[1] = q(1285); b[2] = q(768);
        run("restart");
        check_out("restart", 0, 5, 0, 5, 1'b0, 1'b0);

        // Asynchronous reset after edge 7 of a fresh run.
        load_general();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 7; e++) tick();
        check_eq("pre_rst_r0", r[0], q(10));
        I_RSTn = 1'b0;
        #1;
        check_out("rst_mid", 0, 0, 0, 0, 1'b0, 1'b0);
        check_eq("rst_mid_ready", ready, 1'b0);
        tick();
        I_RSTn = 1'b1;
        for (int e = 0; e < 20; e++) tick();
        check_eq("post_rst_ready", ready, 1'b0);
        check_eq("post_rst_r0", r[0], q(0));

        // A new start after release still works.
        run("post_rst_run");
        check_out("post_rst_run", 10, 0, -8, 10, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
